// File: rtl/text_cell_pkg.sv
// rtl/text_cell_pkg.sv - default text-cell geometry and derived widths for text_cell_xy
package text_cell_pkg;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int DEF_CELL_W  = 9;
  localparam int DEF_CELL_H  = 9;
  localparam int DEF_GLYPH_W = 8;
  localparam int DEF_GLYPH_H = 8;
  localparam int DEF_COLS    = 53;
  localparam int DEF_ROWS    = 30;
  localparam int DEF_CN_W    = 11;

  localparam int DEF_CX_W  = clog2_min1(DEF_GLYPH_W);
  localparam int DEF_CY_W  = clog2_min1(DEF_GLYPH_H);
  localparam int DEF_COL_W = clog2_min1(DEF_COLS + 1);
  localparam int DEF_ROW_W = clog2_min1(DEF_ROWS + 1);
  localparam int DEF_SR_W  = clog2_min1(DEF_ROWS);

endpackage

// File: rtl/cell_axis_counter.sv
// rtl/cell_axis_counter.sv - one raster axis: pitch counter, saturating cell index, glyph-clamped local position
module cell_axis_counter
  import text_cell_pkg::*;
#(
  parameter int PITCH = DEF_CELL_W,
  parameter int GLYPH = DEF_GLYPH_W,
  parameter int CELLS = DEF_COLS,
  parameter int IDX_W = clog2_min1(CELLS + 1),
  parameter int LOC_W = clog2_min1(GLYPH)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] idx,
  output logic [LOC_W-1:0] local_pos,
  output logic             in_glyph,
  output logic             in_grid,
  output logic             step
);

  localparam int CNT_W = clog2_min1(PITCH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(PITCH - 1);
  localparam logic [CNT_W:0]   GLYPH_C = (CNT_W + 1)'(GLYPH);
  localparam logic [IDX_W-1:0] CELLS_C = IDX_W'(CELLS);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  always_comb begin
    wrap      = advance & (cnt == LAST);
    in_glyph  = ({1'b0, cnt} < GLYPH_C);
    in_grid   = (idx < CELLS_C);
    local_pos = in_glyph ? cnt[LOC_W-1:0] : LOC_W'(GLYPH - 1);
    // index stops at CELLS so everything past the grid reads as out-of-grid
    step      = ~clear & wrap & in_grid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (clear) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (advance) cnt <= wrap ? '0 : cnt + 1'b1;
      if (step)    idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/text_cell_xy.sv
// rtl/text_cell_xy.sv - pixel-to-text-cell coordinate decoder; TEXT_CELL_XY_SCROLL_EN adds row scrolling of o_cellnum
module text_cell_xy
  import text_cell_pkg::*;
#(
  parameter int CELL_W  = DEF_CELL_W,
  parameter int CELL_H  = DEF_CELL_H,
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int GLYPH_H = DEF_GLYPH_H,
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int CN_W    = DEF_CN_W,
  localparam int CX_W   = clog2_min1(GLYPH_W),
  localparam int CY_W   = clog2_min1(GLYPH_H),
  localparam int COL_W  = clog2_min1(COLS + 1),
  localparam int ROW_W  = clog2_min1(ROWS + 1)
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_lcden,
`ifdef TEXT_CELL_XY_SCROLL_EN
  input  logic [clog2_min1(ROWS)-1:0] i_scroll_row,
`endif
  output logic             o_pxen,
  output logic [CX_W-1:0]  o_char_x,
  output logic [CY_W-1:0]  o_char_y,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic [CN_W-1:0]  o_cellnum,
  output logic             o_frame_start
);

  logic             hs_d, vs_d, armed, hs_rise;
  logic [COL_W-1:0] x_idx;
  logic [CX_W-1:0]  x_loc;
  logic             x_in_glyph, x_in_grid, x_step_unused;
  logic [ROW_W-1:0] y_idx;
  logic [CY_W-1:0]  y_loc;
  logic             y_in_glyph, y_in_grid, y_step;
  logic [CN_W-1:0]  rowbase, cn_sum;

  assign hs_rise = i_hsync & ~hs_d;
  assign cn_sum  = rowbase + CN_W'(x_idx);

  cell_axis_counter #(
    .PITCH(CELL_W), .GLYPH(GLYPH_W), .CELLS(COLS), .IDX_W(COL_W), .LOC_W(CX_W)
  ) u_x (
    .clk(i_clk), .rst(i_rst), .clear(i_hsync), .advance(i_lcden),
    .idx(x_idx), .local_pos(x_loc), .in_glyph(x_in_glyph), .in_grid(x_in_grid),
    .step(x_step_unused)
  );

  cell_axis_counter #(
    .PITCH(CELL_H), .GLYPH(GLYPH_H), .CELLS(ROWS), .IDX_W(ROW_W), .LOC_W(CY_W)
  ) u_y (
    .clk(i_clk), .rst(i_rst), .clear(i_vsync), .advance(hs_rise),
    .idx(y_idx), .local_pos(y_loc), .in_glyph(y_in_glyph), .in_grid(y_in_grid),
    .step(y_step)
  );

`ifdef TEXT_CELL_XY_SCROLL_EN
  localparam logic [CN_W:0] TOTAL = (CN_W + 1)'(ROWS * COLS);
  logic [CN_W:0]                 rb_add, rb_next;
  logic [clog2_min1(ROWS)-1:0]   init_left;

  always_comb begin
    rb_add  = {1'b0, rowbase} + (CN_W + 1)'(COLS);
    rb_next = (rb_add >= TOTAL) ? rb_add - TOTAL : rb_add;
  end

  // rowbase walks up to scroll*COLS one add per cycle while vsync is held
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rowbase   <= '0;
      init_left <= '0;
    end else if (i_vsync & ~vs_d) begin
      rowbase   <= '0;
      init_left <= i_scroll_row;
    end else if (i_vsync) begin
      if (init_left != '0) begin
        rowbase   <= rb_next[CN_W-1:0];
        init_left <= init_left - 1'b1;
      end
    end else if (y_step) begin
      rowbase <= rb_next[CN_W-1:0];
    end
  end
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        rowbase <= '0;
    else if (i_vsync) rowbase <= '0;
    else if (y_step)  rowbase <= rowbase + CN_W'(COLS);
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hs_d          <= 1'b0;
      vs_d          <= 1'b0;
      armed         <= 1'b0;
      o_frame_start <= 1'b0;
      o_pxen        <= 1'b0;
      o_char_x      <= '0;
      o_char_y      <= '0;
      o_col         <= '0;
      o_row         <= '0;
      o_cellnum     <= '0;
    end else begin
      hs_d <= i_hsync;
      vs_d <= i_vsync;
      if (i_vsync)      armed <= 1'b1;
      else if (i_lcden) armed <= 1'b0;
      o_frame_start <= i_lcden & armed & ~i_vsync;
      o_pxen        <= i_lcden & x_in_glyph & y_in_glyph & x_in_grid & y_in_grid;
      if (i_lcden) begin
        o_char_x  <= x_loc;
        o_char_y  <= y_loc;
        o_col     <= x_idx;
        o_row     <= y_idx;
        o_cellnum <= cn_sum;
      end
    end
  end

endmodule

// File: tb/tb_text_cell_xy.sv
// tb/tb_text_cell_xy.sv - randomized raster stimulus against a position-based reference model
module tb_text_cell_xy;

  localparam int CW = 9, CH = 9, GW = 8, GH = 8, COLS = 53, ROWS = 30, CN_W = 11;

  logic        clk = 1'b0;
  logic        rst, hs, vs, de;
  logic        o_pxen, o_frame_start;
  logic [2:0]  o_char_x, o_char_y;
  logic [5:0]  o_col;
  logic [4:0]  o_row;
  logic [10:0] o_cellnum;
`ifdef TEXT_CELL_XY_SCROLL_EN
  logic [4:0]  scroll = 5'd0;
`endif

  always #5 clk = ~clk;

  text_cell_xy #(
    .CELL_W(CW), .CELL_H(CH), .GLYPH_W(GW), .GLYPH_H(GH),
    .COLS(COLS), .ROWS(ROWS), .CN_W(CN_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_hsync(hs), .i_vsync(vs), .i_lcden(de),
`ifdef TEXT_CELL_XY_SCROLL_EN
    .i_scroll_row(scroll),
`endif
    .o_pxen(o_pxen), .o_char_x(o_char_x), .o_char_y(o_char_y), .o_col(o_col),
    .o_row(o_row), .o_cellnum(o_cellnum), .o_frame_start(o_frame_start)
  );

  int tests = 0, fails = 0;
  int pix, line, hs_prev, armed_m, fs_count, scroll_m;
  logic        e_px, e_fs;
  logic [2:0]  e_cx, e_cy;
  logic [5:0]  e_col;
  logic [4:0]  e_row;
  logic [10:0] e_cn;
  logic [2:0]  q_cx[$];
  int          q_col[$];
  logic        q_px[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    pix = 0; line = 0; hs_prev = 0; armed_m = 0;
    e_px = 0; e_fs = 0; e_cx = 0; e_cy = 0; e_col = 0; e_row = 0; e_cn = 0;
  endtask

  // Expected outputs come from the pixel/line position since the last sync
  task automatic step(input logic h, input logic v, input logic d);
    int x, y, c, r, er;
    logic [29:0] obs, expv;
    hs = h; vs = v; de = d;
    x = pix % CW;  y = line % CH;
    c = imin(pix / CW, COLS);  r = imin(line / CH, ROWS);
    er = r;
`ifdef TEXT_CELL_XY_SCROLL_EN
    if (v) scroll_m = int'(scroll);
    er = (r + scroll_m) % ROWS;
`endif
    if (d) begin
      e_cx  = 3'((x < GW) ? x : GW - 1);
      e_cy  = 3'((y < GH) ? y : GH - 1);
      e_col = 6'(c);
      e_row = 5'(r);
      e_cn  = 11'((er * COLS + c) % (1 << CN_W));
    end
    e_px = d && (x < GW) && (y < GH) && (c < COLS) && (r < ROWS);
    e_fs = d && (armed_m != 0) && !v;
    if (h) pix = 0; else if (d) pix++;
    if (v) line = 0; else if (h && hs_prev == 0) line++;
    hs_prev = int'(h);
    if (v) armed_m = 1; else if (d) armed_m = 0;
    @(posedge clk); #1;
    fs_count += int'(o_frame_start);
    obs  = {o_pxen, o_char_x, o_char_y, o_col, o_row, o_cellnum, o_frame_start};
    expv = {e_px, e_cx, e_cy, e_col, e_row, e_cn, e_fs};
    check("outputs", 32'(obs), 32'(expv));
  endtask

  task automatic vsync_blank(input int n);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < n; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic hsync_pulse();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pixels(input int n, input bit gaps);
    q_cx.delete(); q_col.delete(); q_px.delete();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      q_cx.push_back(o_char_x);
      q_col.push_back(int'(o_col));
      q_px.push_back(o_pxen);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cx_tab[19];
    logic any_px;
    for (int i = 0; i < 19; i++) cx_tab[i] = (i == 8 || i == 17) ? 7 : (i % 9);
    rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({o_pxen, o_char_x, o_char_y, o_col, o_row, o_cellnum, o_frame_start}), 32'd0);
    rst = 1'b0;

    // frame 1: vsync and hsync rise together, then line 0 of 20 pixels
    fs_count = 0;
    vsync_blank(4);
    pixels(20, 1'b0);
    for (int i = 0; i < 19; i++) check("line0_char_x", 32'(q_cx[i]), 32'(cx_tab[i]));
    for (int i = 0; i < 20; i++) check("line0_col", 32'(q_col[i]), 32'((i < 9) ? 0 : (i < 18) ? 1 : 2));
    for (int i = 0; i < 20; i++) check("line0_pxen", 32'(q_px[i]), 32'((i == 8 || i == 17) ? 0 : 1));
    check("line0_row", 32'(o_row), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    for (int ln = 1; ln <= 8; ln++) begin
      hsync_pulse();
      pixels($urandom_range(5, 40), 1'b1);
    end
    any_px = 1'b0;
    foreach (q_px[i]) any_px |= q_px[i];
    check("line8_pxen_low", 32'(any_px), 32'd0);
    hsync_pulse();
    pixels(1, 1'b0);
    check("row1_row", 32'(o_row), 32'd1);
    check("row1_char_y", 32'(o_char_y), 32'd0);
    check("row1_cellnum", 32'(o_cellnum), 32'd53);
    for (int ln = 10; ln <= 275; ln++) begin
      hsync_pulse();
      pixels($urandom_range(1, 12), 1'b1);
    end
    check("row_saturated", 32'(o_row), 32'd30);
    check("row_sat_pxen", 32'(o_pxen), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("frame1_start_count", 32'(fs_count), 32'd1);

    // frame 2: one 480-pixel line runs the column index into saturation
    fs_count = 0;
    vsync_blank(4);
    pixels(480, 1'b0);
    for (int i = 477; i < 480; i++) begin
      check("col_saturated", 32'(q_col[i]), 32'd53);
      check("col_sat_pxen", 32'(q_px[i]), 32'd0);
    end
    check("col_sat_cellnum", 32'(o_cellnum), 32'd53);
    step(1'b0, 1'b0, 1'b0);
    check("frame2_start_count", 32'(fs_count), 32'd1);

    // asynchronous reset in the middle of an active line
    hsync_pulse();
    pixels(7, 1'b0);
    hs = 1'b0; vs = 1'b0; de = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_reset", 32'({o_pxen, o_char_x, o_char_y, o_col, o_row, o_cellnum, o_frame_start}), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    fs_count = 0;
    vsync_blank(4);
    pixels(1, 1'b0);
    check("restart_cellnum", 32'(o_cellnum), 32'd0);
    check("restart_frame_start", 32'(o_frame_start), 32'd1);
    pixels(15, 1'b1);
    for (int ln = 1; ln <= 12; ln++) begin
      hsync_pulse();
      pixels($urandom_range(10, 60), 1'b1);
    end
    check("frame3_start_count", 32'(fs_count), 32'd1);

`ifdef TEXT_CELL_XY_SCROLL_EN
    scroll = 5'd29;
    vsync_blank(35);
    pixels(1, 1'b0);
    check("scroll_row0_cellnum", 32'(o_cellnum), 32'd1537);
    check("scroll_row0_row", 32'(o_row), 32'd0);
    for (int ln = 1; ln <= 9; ln++) begin
      hsync_pulse();
      if (ln < 9) pixels($urandom_range(3, 20), 1'b1);
    end
    pixels(1, 1'b0);
    check("scroll_row1_cellnum", 32'(o_cellnum), 32'd0);
    check("scroll_row1_row", 32'(o_row), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
